beta_imem_responder: RTL and testbench
======================================

# beta_imem_responder

Memory-side responder for the IF-stage instruction-memory request/ready/valid protocol. Accepts a fetch request, returns a one-cycle `ready` acknowledge, then after a configurable latency returns a one-cycle `valid` pulse with the instruction word read from an internal word array. The block is the simulation/FPGA instruction memory behind the fetch unit. A preload write port fills the array before or between fetches.

## Interface
- `DataWidth`, 32: instruction word width.
- `AddrWidth`, 32: byte address width.
- `MemDepth`, 1024: number of words in the array; a power of two, at least 2.
- `AcceptDelay`, 0: extra cycles, 0..15, between first seeing `req` and asserting `ready`.
- `ReadLatency`, 1: cycles, 1..15, from the `ready` cycle to the `valid` cycle.
- `clk_i` in 1: the single clock.
- `rst_i` in 1: reset, synchronous and active-high.
- `imem_req_i` in 1: fetch request from the fetch unit.
- `imem_addr_i` in AddrWidth: byte address. Valid while `imem_req_i` is high.
- `imem_ready_o` out 1: request accepted. One-cycle pulse.
- `imem_valid_o` out 1: read data valid. One-cycle pulse.
- `imem_rdata_o` out DataWidth: instruction word. Holds its value between pulses.
- `imem_err_o` out 1: the access was out of range or misaligned. Pulses together with `imem_valid_o`.
- `imem_busy_o` out 1: a transaction is in progress (any state other than IDLE).
- `load_we_i` in 1: preload write enable.
- `load_addr_i` in AddrWidth: preload byte address (word index = `load_addr_i[AddrWidth-1:2]`).
- `load_wdata_i` in DataWidth: preload write data.

## Operation
- FSM states: IDLE, DELAY, ACK, WAIT, RESP.
- IDLE:
  - On `imem_req_i`=1, capture `imem_addr_i`.
  - Go to DELAY if `AcceptDelay`>0, otherwise go to ACK.
- DELAY: count `AcceptDelay` cycles, then go to ACK. `imem_req_i` is not re-checked here; the request is considered committed once captured.
- ACK:
  - `imem_ready_o`=1 for this cycle only.
  - `imem_req_i` is still high in this cycle and is not treated as a new request.
  - Go to WAIT if `ReadLatency`>1, otherwise go to RESP.
- WAIT: count `ReadLatency`-1 cycles, then go to RESP.
- RESP:
  - `imem_valid_o`=1 for this cycle only. Register `imem_rdata_o`/`imem_err_o` so they are stable in this cycle.
  - Return to IDLE.
  - A new request can be sampled in the next IDLE cycle. `imem_req_i` is ignored in RESP.
- Address check on the captured address:
  - Word index = addr[AddrWidth-1:2].
  - Error if addr[1:0]≠0 or index ≥ MemDepth.
  - On error: `imem_rdata_o`=32'h00000013 (NOP) and `imem_err_o`=1.
  - Otherwise: `imem_rdata_o`=mem[index] and `imem_err_o`=0.
- Preload port:
  - When `load_we_i`=1, write mem[index] in any state.
  - Writes to an out-of-range index, or with load_addr[1:0]≠0, are dropped silently.
- Read/write collision: if the word is read at the same edge it is preloaded, the read returns the old value. The new value is visible from the next read.
- The array is not cleared by reset.

## Timing
- Reset values: `imem_ready_o`=0, `imem_valid_o`=0, `imem_err_o`=0, `imem_busy_o`=0, `imem_rdata_o`=0. State is IDLE and counters are 0.
- Reset asserted mid-transaction aborts it: no `ready`/`valid` pulse follows, and the FSM is in IDLE at the cycle after the reset edge.
- All outputs are registered.
- With `imem_req_i` first high in cycle c:
  - `imem_ready_o` is high in cycle c+1+`AcceptDelay`.
  - `imem_valid_o` is high in cycle c+1+`AcceptDelay`+`ReadLatency`.
- Defaults (A=0, L=1): `ready` at c+1 and `valid` at c+2. Combined with the fetch unit's registered capture, the instruction is available at c+3.
- `imem_busy_o` is high from cycle c+1 through the RESP cycle inclusive.
- Back-to-back fetches: minimum spacing between `valid` pulses is 2+`AcceptDelay`+`ReadLatency` cycles.

## Test plan
- Defaults:
  - Stimulus: preload mem[4]=32'h00500093, then hold req with addr=0x10 in cycle 5.
  - Response: ready in cycle 6 only; valid in cycle 7 with rdata=32'h00500093 and err=0; busy high in cycles 6–7.
- AcceptDelay=3, ReadLatency=4:
  - Stimulus: req in cycle 10.
  - Response: ready only in cycle 14; valid only in cycle 18; req still high in cycle 14 does not start a second transaction.
- Out of range (MemDepth=1024):
  - Stimulus: request addr=0x1000.
  - Response: normal ready/valid timing; rdata=32'h00000013; err=1 in the valid cycle only.
- Misaligned:
  - Stimulus: request addr=0x12.
  - Response: rdata=32'h00000013, err=1. Then request addr=0x10: err=0 and the correct data.
- Reset mid-operation:
  - Stimulus: assert rst_i in the cycle between ready and valid.
  - Response: no valid pulse; all outputs are 0 the next cycle; a following request completes normally and the array contents are preserved.
- Collision:
  - Stimulus: preload mem[4]=32'h11111111, then `load_we_i` writes 32'h22222222 to mem[4] on the same edge the read is registered.
  - Response: rdata=32'h11111111; the next fetch of 0x10 returns 32'h22222222.

Source files
------------

// File: rtl/beta_imem_responder.sv
// beta_imem_responder: instruction memory behind the fetch unit, answering req with a ready pulse
// and, after a fixed latency, a valid pulse carrying the word; a preload port fills the array.
module beta_imem_responder #(
  parameter int DataWidth   = 32,
  parameter int AddrWidth   = 32,
  parameter int MemDepth    = 1024,
  parameter int AcceptDelay = 0,
  parameter int ReadLatency = 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 imem_req_i,
  input  logic [AddrWidth-1:0] imem_addr_i,
  output logic                 imem_ready_o,
  output logic                 imem_valid_o,
  output logic [DataWidth-1:0] imem_rdata_o,
  output logic                 imem_err_o,
  output logic                 imem_busy_o,
  input  logic                 load_we_i,
  input  logic [AddrWidth-1:0] load_addr_i,
  input  logic [DataWidth-1:0] load_wdata_i
);
  localparam int IW = $clog2(MemDepth);
  localparam logic [3:0] DLAST = 4'(AcceptDelay > 0 ? AcceptDelay - 1 : 0);
  localparam logic [3:0] WLAST = 4'(ReadLatency > 1 ? ReadLatency - 2 : 0);
  localparam logic [DataWidth-1:0] NOP = DataWidth'(32'h0000_0013);
  typedef enum logic [2:0] {IDLE, DELAY, ACK, WAIT, RESP} state_t;
  state_t state, nxt;
  logic [3:0] cnt;
  logic [AddrWidth-1:0] addr_q;
  logic [DataWidth-1:0] mem [MemDepth];
  logic bad, load_ok;
  assign bad = addr_q[1:0] != 2'b00 || |addr_q[AddrWidth-1:IW+2];
  assign load_ok = load_we_i && load_addr_i[1:0] == 2'b00 && !(|load_addr_i[AddrWidth-1:IW+2]);
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state  <= IDLE;
      cnt    <= '0;
      addr_q <= '0;
    end else begin
      state <= nxt;
      cnt   <= (nxt == state) ? cnt + 4'd1 : 4'd0;
      if (state == IDLE && imem_req_i) addr_q <= imem_addr_i;
    end
  end
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = imem_req_i ? (AcceptDelay > 0 ? DELAY : ACK) : IDLE;
      DELAY:   nxt = cnt == DLAST ? ACK : DELAY;
      ACK:     nxt = ReadLatency > 1 ? WAIT : RESP;
      WAIT:    nxt = cnt == WLAST ? RESP : WAIT;
      default: nxt = IDLE;
    endcase
  end
  // outputs are registered from the next state so each pulse lines up with its state
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      imem_ready_o <= 1'b0;
      imem_valid_o <= 1'b0;
      imem_busy_o  <= 1'b0;
      imem_err_o   <= 1'b0;
      imem_rdata_o <= '0;
    end else begin
      imem_ready_o <= nxt == ACK;
      imem_valid_o <= nxt == RESP;
      imem_busy_o  <= nxt != IDLE;
      imem_err_o   <= nxt == RESP && bad;
      if (nxt == RESP) imem_rdata_o <= bad ? NOP : mem[addr_q[IW+1:2]];
    end
  end
  // preload is not reset so the program survives a core reset
  always_ff @(posedge clk_i) begin
    if (load_ok) mem[load_addr_i[IW+1:2]] <= load_wdata_i;
  end
endmodule

// File: tb/tb_beta_imem_responder.sv
// tb_beta_imem_responder: two responders (A=0/L=1 and A=3/L=4) checked every cycle against a
// transaction-level timing model plus directed literal checks.
module tb_beta_imem_responder;
  logic clk = 1'b0;
  logic rst;
  logic [1:0] req, rdy, val, err, bsy;
  logic [31:0] addr [2];
  logic [31:0] rdata [2];
  logic load_we;
  logic [31:0] load_addr, load_wdata;
  int errors = 0;
  int checks = 0;
  always #5 clk = ~clk;
  function automatic int ad(int k);
    return k == 0 ? 0 : 3;
  endfunction
  function automatic int lt(int k);
    return k == 0 ? 1 : 4;
  endfunction
  for (genvar g = 0; g < 2; g++) begin : g_dut
    beta_imem_responder #(.AcceptDelay(g == 0 ? 0 : 3), .ReadLatency(g == 0 ? 1 : 4)) u_dut (
      .clk_i(clk), .rst_i(rst), .imem_req_i(req[g]), .imem_addr_i(addr[g]),
      .imem_ready_o(rdy[g]), .imem_valid_o(val[g]), .imem_rdata_o(rdata[g]),
      .imem_err_o(err[g]), .imem_busy_o(bsy[g]), .load_we_i(load_we),
      .load_addr_i(load_addr), .load_wdata_i(load_wdata));
  end
  // model: a transaction is a count of cycles since its request was taken
  logic [31:0] mem_m [1024];
  bit m_busy [2];
  int m_t [2];
  logic [31:0] m_addr [2];
  logic e_rdy [2], e_val [2], e_busy [2], e_err [2];
  logic [31:0] e_rdata [2];
  logic bad;
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        m_busy[k] = 0; e_rdy[k] = 0; e_val[k] = 0; e_busy[k] = 0; e_err[k] = 0; e_rdata[k] = 0;
      end else begin
        if (!m_busy[k]) begin
          if (req[k]) begin m_busy[k] = 1; m_t[k] = 1; m_addr[k] = addr[k]; end
        end else if (m_t[k] == 1 + ad(k) + lt(k)) m_busy[k] = 0;
        else m_t[k]++;
        e_busy[k] = m_busy[k];
        e_rdy[k] = m_busy[k] && m_t[k] == 1 + ad(k);
        e_val[k] = m_busy[k] && m_t[k] == 1 + ad(k) + lt(k);
        e_err[k] = 0;
        if (e_val[k]) begin
          bad = m_addr[k][1:0] != 0 || m_addr[k][31:2] >= 1024;
          e_err[k] = bad;
          e_rdata[k] = bad ? 32'h13 : mem_m[m_addr[k][11:2]];
        end
      end
    end
    if (load_we && load_addr[1:0] == 0 && load_addr[31:2] < 1024) mem_m[load_addr[11:2]] = load_wdata;
  end
  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h at %0t", nm, got, exp, $time);
    end
  endtask
  task automatic tick();
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("k%0d_ready", k), 32'(rdy[k]), 32'(e_rdy[k]));
      chk($sformatf("k%0d_valid", k), 32'(val[k]), 32'(e_val[k]));
      chk($sformatf("k%0d_busy", k), 32'(bsy[k]), 32'(e_busy[k]));
      chk($sformatf("k%0d_err", k), 32'(err[k]), 32'(e_err[k]));
      chk($sformatf("k%0d_rdata", k), rdata[k], e_rdata[k]);
    end
  endtask
  // one fetch, req held through the ready cycle; optional preload of the same word on the read edge
  task automatic fetch(input int k, input logic [31:0] a, input bit coll, input logic [31:0] cw,
                       input logic [31:0] xd, input logic xe);
    int rl = -1, vl = -1, nr = 0, nv = 0;
    logic [31:0] d = 'x;
    logic e = 1'bx;
    req[k] = 1; addr[k] = a;
    for (int n = 1; n <= 40 && vl < 0; n++) begin
      tick();
      load_we = 0;
      if (rl >= 0 && n == rl + 1) req[k] = 0;
      if (rdy[k]) begin
        nr++;
        if (rl < 0) begin
          rl = n;
          if (coll) begin load_we = 1; load_addr = a; load_wdata = cw; end
        end
      end
      if (val[k]) begin nv++; vl = n; d = rdata[k]; e = err[k]; end
    end
    req[k] = 0;
    load_we = 0;
    for (int n = 0; n < 4; n++) begin
      tick();
      if (rdy[k]) nr++;
      if (val[k]) nv++;
    end
    chk($sformatf("k%0d_ready_lat", k), rl, 1 + ad(k));
    chk($sformatf("k%0d_valid_lat", k), vl, 1 + ad(k) + lt(k));
    chk($sformatf("k%0d_ready_count", k), nr, 1);
    chk($sformatf("k%0d_valid_count", k), nv, 1);
    chk($sformatf("k%0d_data_%h", k, a), d, xd);
    chk($sformatf("k%0d_errflag_%h", k, a), 32'(e), 32'(xe));
  endtask
  function automatic logic [31:0] rnd_addr();
    int r = $urandom_range(15);
    logic [31:0] w = 32'($urandom_range(31)) << 2;
    return r < 12 ? w : r < 14 ? w + 32'($urandom_range(3, 1)) : r == 14 ? 32'h1000 + w : $urandom;
  endfunction
  initial begin
    int n, seen;
    rst = 1; req = '0; addr[0] = 0; addr[1] = 0; load_we = 0; load_addr = 0; load_wdata = 0;
    repeat (3) tick();
    rst = 0;
    for (int w = 0; w < 32; w++) begin
      load_we = 1; load_addr = 32'(w * 4); load_wdata = (w == 4) ? 32'h00500093 : $urandom;
      tick();
    end
    load_we = 0;
    tick();
    fetch(0, 32'h10, 0, 0, 32'h00500093, 0);
    fetch(1, 32'h10, 0, 0, 32'h00500093, 0);
    fetch(0, 32'h1000, 0, 0, 32'h13, 1);
    fetch(1, 32'h1000, 0, 0, 32'h13, 1);
    fetch(0, 32'h12, 0, 0, 32'h13, 1);
    fetch(0, 32'h10, 0, 0, 32'h00500093, 0);
    req[1] = 1; addr[1] = 32'h10; n = 0;
    while (!rdy[1] && n < 20) begin tick(); n++; end
    chk("rst_pre_ready", 32'(rdy[1]), 1);
    req[1] = 0;
    tick();
    rst = 1;
    tick();
    rst = 0;
    chk("rst_ready", 32'(rdy[1]), 0);
    chk("rst_valid", 32'(val[1]), 0);
    chk("rst_busy", 32'(bsy[1]), 0);
    chk("rst_err", 32'(err[1]), 0);
    chk("rst_rdata", rdata[1], 0);
    seen = 0;
    for (int i = 0; i < 12; i++) begin tick(); seen += 32'(val[1]); end
    chk("rst_no_valid", seen, 0);
    fetch(1, 32'h10, 0, 0, 32'h00500093, 0);
    load_we = 1; load_addr = 32'h10; load_wdata = 32'h11111111;
    tick();
    load_we = 0;
    fetch(0, 32'h10, 1, 32'h22222222, 32'h11111111, 0);
    fetch(0, 32'h10, 0, 0, 32'h22222222, 0);
    for (int i = 0; i < 3000; i++) begin
      rst = $urandom_range(249) == 0;
      load_we = $urandom_range(3) == 0; load_addr = rnd_addr(); load_wdata = $urandom;
      for (int k = 0; k < 2; k++) begin
        if (req[k] && rdy[k]) req[k] = 0;
        else if (!req[k] && $urandom_range(2) == 0) begin req[k] = 1; addr[k] = rnd_addr(); end
      end
      tick();
    end
    rst = 0; load_we = 0; req = '0;
    repeat (20) tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
